// File: rtl/bsk_bdc_slot_arbiter_pkg.sv
// Shared parameters for the bsk broadcast network, plus helpers used by
// the slot arbiter.
package bsk_ntw_common_param_pkg;
  localparam int BSK_BDC_BURST_MAX = 16;
  localparam int BSK_BDC_GUARD_CYC = 2;
endpackage

package bsk_bdc_slot_arbiter_pkg;
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // A zero-length burst, or one longer than the counter can track, is never granted.
  function automatic logic len_legal(input int len, input int max_len);
    return (len != 0) && (len <= max_len);
  endfunction
endpackage

// File: rtl/bsk_bdc_slot_arbiter_if.sv
// Request/grant bundle between the bsk servers and the broadcast slot arbiter.
interface bsk_bdc_slot_arbiter_if
  import bsk_ntw_common_param_pkg::*;
  import bsk_bdc_slot_arbiter_pkg::*;
#(
  parameter int SRV_NB    = 6,
  parameter int BURST_MAX = BSK_BDC_BURST_MAX
);
  localparam int BURST_W = $clog2(BURST_MAX + 1);
  localparam int IDX_W   = idx_width(SRV_NB);

  logic                            arb_en;
  logic [SRV_NB-1:0]               srv_req;
  logic [SRV_NB-1:0][BURST_W-1:0]  srv_req_len;
  logic [SRV_NB-1:0]               srv_gnt;
  logic                            gnt_last;
  logic [IDX_W-1:0]                owner_id;
  logic                            busy;
  logic                            err_len;

  modport master (
    output arb_en, srv_req, srv_req_len,
    input  srv_gnt, gnt_last, owner_id, busy, err_len
  );

  modport slave (
    input  arb_en, srv_req, srv_req_len,
    output srv_gnt, gnt_last, owner_id, busy, err_len
  );
endinterface

// File: rtl/bsk_bdc_slot_arbiter_rr_pick.sv
// Round-robin picker: first set request at or after the pointer, wrapping.
module bsk_bdc_rr_pick #(
  parameter int SRV_NB = 6,
  parameter int IDX_W  = 3
) (
  input  logic [SRV_NB-1:0] req_i,
  input  logic [IDX_W-1:0]  ptr_i,
  output logic [SRV_NB-1:0] onehot_o,
  output logic [IDX_W-1:0]  idx_o,
  output logic              found_o
);
  logic [IDX_W-1:0] cand;

  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    found_o  = 1'b0;
    cand     = '0;
    for (int i = 0; i < SRV_NB; i++) begin
      cand = IDX_W'((int'(ptr_i) + i) % SRV_NB);
      if (!found_o && req_i[cand]) begin
        found_o         = 1'b1;
        idx_o           = cand;
        onehot_o[cand]  = 1'b1;
      end
    end
  end
endmodule

// File: rtl/bsk_bdc_slot_arbiter.sv
// Time-slot arbiter for the shared broadcast OR tree: one server at a time,
// fixed-length bursts, guard gap between bursts. All outputs are flops.
module bsk_bdc_slot_arbiter
  import bsk_ntw_common_param_pkg::*;
  import bsk_bdc_slot_arbiter_pkg::*;
#(
  parameter int SRV_NB    = 6,
  parameter int BURST_MAX = BSK_BDC_BURST_MAX,
  parameter int GUARD_CYC = BSK_BDC_GUARD_CYC
) (
  input logic                   clk,
  input logic                   a_rst,
  bsk_bdc_slot_arbiter_if.slave bus
);
  localparam int BURST_W    = $clog2(BURST_MAX + 1);
  localparam int IDX_W      = idx_width(SRV_NB);
  localparam int GCNT_W     = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;
  localparam int GUARD_LOAD = (GUARD_CYC > 0) ? GUARD_CYC - 1 : 0;

  typedef enum logic [1:0] {IDLE, GRANT, GUARD} state_e;

  state_e             state_q, state_d;
  logic [BURST_W-1:0] beat_q, beat_d;
  logic [GCNT_W-1:0]  guard_q, guard_d;
  logic [IDX_W-1:0]   rr_q, rr_d;
  logic [SRV_NB-1:0]  gnt_q, gnt_d;
  logic               last_q, last_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;

  logic [SRV_NB-1:0]  valid_vec;
  logic [SRV_NB-1:0]  bad_vec;
  logic [SRV_NB-1:0]  win_oh;
  logic [IDX_W-1:0]   win_idx;
  logic               win_found;
  logic [BURST_W-1:0] len_sel;

  always_comb begin
    valid_vec = '0;
    bad_vec   = '0;
    for (int i = 0; i < SRV_NB; i++) begin
      valid_vec[i] = bus.srv_req[i] & len_legal(int'(bus.srv_req_len[i]), BURST_MAX);
      bad_vec[i]   = bus.srv_req[i] & ~len_legal(int'(bus.srv_req_len[i]), BURST_MAX);
    end
  end

  bsk_bdc_rr_pick #(
    .SRV_NB (SRV_NB),
    .IDX_W  (IDX_W)
  ) u_pick (
    .req_i    (valid_vec),
    .ptr_i    (rr_q),
    .onehot_o (win_oh),
    .idx_o    (win_idx),
    .found_o  (win_found)
  );

  assign len_sel = bus.srv_req_len[win_idx];

  // Output values are computed for the next state so every port comes straight off a flop.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    guard_d = guard_q;
    rr_d    = rr_q;
    gnt_d   = '0;
    last_d  = 1'b0;
    owner_d = '0;
    busy_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.arb_en) begin
          err_d = |bad_vec;
          if (win_found) begin
            state_d = GRANT;
            beat_d  = len_sel - BURST_W'(1);
            rr_d    = (win_idx == IDX_W'(SRV_NB - 1)) ? '0 : win_idx + IDX_W'(1);
            gnt_d   = win_oh;
            owner_d = win_idx;
            last_d  = (len_sel == BURST_W'(1));
            busy_d  = 1'b1;
          end
        end
      end
      GRANT: begin
        if (beat_q == '0) begin
          if (GUARD_CYC > 0) begin
            state_d = GUARD;
            guard_d = GCNT_W'(GUARD_LOAD);
            busy_d  = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          beat_d  = beat_q - BURST_W'(1);
          gnt_d   = gnt_q;
          owner_d = owner_q;
          last_d  = (beat_q == BURST_W'(1));
          busy_d  = 1'b1;
        end
      end
      GUARD: begin
        if (guard_q == '0) begin
          state_d = IDLE;
        end else begin
          guard_d = guard_q - GCNT_W'(1);
          busy_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      guard_q <= '0;
      rr_q    <= '0;
      gnt_q   <= '0;
      last_q  <= 1'b0;
      owner_q <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      guard_q <= guard_d;
      rr_q    <= rr_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign bus.srv_gnt  = gnt_q;
  assign bus.gnt_last = last_q;
  assign bus.owner_id = owner_q;
  assign bus.busy     = busy_q;
  assign bus.err_len  = err_q;
endmodule

// File: tb/tb_bsk_bdc_slot_arbiter.sv
// Self-checking bench for the broadcast slot arbiter: directed scenarios plus
// random traffic against a burst-window reference model.
module tb_bsk_bdc_slot_arbiter;
  localparam int N  = 6;
  localparam int BM = 16;
  localparam int GC = 2;
  localparam int BW = 5;
  localparam int IW = 3;

  logic clk = 1'b0;
  logic a_rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  bsk_bdc_slot_arbiter_if #(.SRV_NB(N), .BURST_MAX(BM)) bus ();

  bsk_bdc_slot_arbiter #(
    .SRV_NB    (N),
    .BURST_MAX (BM),
    .GUARD_CYC (GC)
  ) dut (
    .clk   (clk),
    .a_rst (a_rst),
    .bus   (bus)
  );

  // Model: a granted burst opens a window of len grant cycles followed by GC guard cycles.
  int   mPos = -1;
  int   mLen = 0;
  int   mOwner = 0;
  int   mRr = 0;
  logic mErr = 1'b0;

  function automatic void modelReset();
    mPos = -1; mLen = 0; mOwner = 0; mRr = 0; mErr = 1'b0;
  endfunction

  function automatic void modelEdge();
    int  win;
    int  c;
    int  l;
    logic r;
    mErr = 1'b0;
    if (mPos >= 0) begin
      mPos++;
      if (mPos == mLen + GC) mPos = -1;
    end else if (bus.arb_en) begin
      win = -1;
      for (int k = 0; k < N; k++) begin
        c = (mRr + k) % N;
        r = bus.srv_req[IW'(c)];
        l = int'(bus.srv_req_len[IW'(c)]);
        if (r && (l < 1 || l > BM)) mErr = 1'b1;
        if (r && l >= 1 && l <= BM && win < 0) win = c;
      end
      if (win >= 0) begin
        mPos = 0; mLen = int'(bus.srv_req_len[IW'(win)]); mOwner = win; mRr = (win + 1) % N;
      end
    end
  endfunction

  function automatic logic inGrant();
    return (mPos >= 0) && (mPos < mLen);
  endfunction

  function automatic logic [N-1:0] expGnt();
    return inGrant() ? (N'(1) << mOwner) : '0;
  endfunction

  function automatic logic [IW-1:0] expOwner();
    return inGrant() ? IW'(mOwner) : '0;
  endfunction

  task automatic tick();
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  task automatic doReset();
    bus.arb_en = 1'b0;
    bus.srv_req = '0;
    bus.srv_req_len = '0;
    a_rst = 1'b1;
    modelReset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    a_rst = 1'b0;
  endtask

  // Always-on monitor: one-hot grant, constant grant within a burst, minimum gap between bursts.
  int cyc = 0;
  int lastG = -1;
  logic [N-1:0] prevG = '0;
  always @(negedge clk) begin
    cyc++;
    if (a_rst) begin
      lastG = -1;
      prevG = '0;
    end else begin
      checks++;
      if (!$onehot0(bus.srv_gnt)) begin
        errors++; $display("[TB] FAIL onehot got %b want at most one bit", bus.srv_gnt);
      end
      if (bus.srv_gnt != '0) begin
        if (prevG == '0 && lastG >= 0) begin
          checks++;
          if (cyc - lastG - 1 < GC + 1) begin
            errors++; $display("[TB] FAIL gap got %0d want >= %0d", cyc - lastG - 1, GC + 1);
          end
        end
        if (prevG != '0) begin
          checks++;
          if (bus.srv_gnt !== prevG) begin
            errors++; $display("[TB] FAIL burst_const got %b want %b", bus.srv_gnt, prevG);
          end
        end
        lastG = cyc;
      end
      prevG = bus.srv_gnt;
    end
  end

  task automatic test_reset();
    doReset();
    checks++; if (bus.srv_gnt !== '0)  begin errors++; $display("[TB] FAIL rst_gnt got %b want 0", bus.srv_gnt); end
    checks++; if (bus.gnt_last !== 1'b0) begin errors++; $display("[TB] FAIL rst_last got %b want 0", bus.gnt_last); end
    checks++; if (bus.owner_id !== '0) begin errors++; $display("[TB] FAIL rst_owner got %0d want 0", bus.owner_id); end
    checks++; if (bus.busy !== 1'b0)   begin errors++; $display("[TB] FAIL rst_busy got %b want 0", bus.busy); end
    checks++; if (bus.err_len !== 1'b0) begin errors++; $display("[TB] FAIL rst_err got %b want 0", bus.err_len); end
  endtask

  task automatic test_single();
    logic [N-1:0] eg;
    doReset();
    bus.arb_en = 1'b1;
    bus.srv_req = 6'b000100;
    bus.srv_req_len[2] = BW'(4);
    for (int c = 1; c <= 7; c++) begin
      tick();
      if (c == 1) bus.srv_req = '0;
      eg = (c <= 4) ? 6'b000100 : 6'b000000;
      checks++; if (bus.srv_gnt !== eg) begin errors++; $display("[TB] FAIL single_gnt c%0d got %b want %b", c, bus.srv_gnt, eg); end
      checks++; if (bus.gnt_last !== (c == 4)) begin errors++; $display("[TB] FAIL single_last c%0d got %b want %b", c, bus.gnt_last, c == 4); end
      checks++; if (bus.busy !== (c <= 6)) begin errors++; $display("[TB] FAIL single_busy c%0d got %b want %b", c, bus.busy, c <= 6); end
      checks++; if (bus.owner_id !== ((c <= 4) ? IW'(2) : IW'(0))) begin
        errors++; $display("[TB] FAIL single_owner c%0d got %0d", c, bus.owner_id);
      end
    end
  endtask

  task automatic test_fairness();
    int order[7];
    int when[7];
    int n;
    doReset();
    bus.arb_en = 1'b1;
    bus.srv_req = 6'b111111;
    for (int k = 0; k < N; k++) bus.srv_req_len[k] = BW'(1);
    n = 0;
    for (int t = 1; t <= 40 && n < 7; t++) begin
      tick();
      if (bus.srv_gnt != '0) begin
        order[n] = -1;
        for (int k = 0; k < N; k++) if (bus.srv_gnt[IW'(k)]) order[n] = k;
        when[n] = t;
        n++;
      end
    end
    checks++;
    if (n != 7) begin
      errors++; $display("[TB] FAIL fair_timeout got %0d grants want 7", n);
    end else begin
      for (int k = 0; k < 7; k++) begin
        checks++;
        if (order[k] != k % N) begin errors++; $display("[TB] FAIL fair_order #%0d got %0d want %0d", k, order[k], k % N); end
        if (k > 0) begin
          checks++;
          if (when[k] - when[k-1] != GC + 2) begin
            errors++; $display("[TB] FAIL fair_spacing #%0d got %0d want %0d", k, when[k] - when[k-1], GC + 2);
          end
        end
      end
    end
    bus.srv_req = '0;
  endtask

  task automatic test_bad_len();
    doReset();
    bus.arb_en = 1'b1;
    bus.srv_req = 6'b001010;
    bus.srv_req_len[1] = BW'(0);
    bus.srv_req_len[3] = BW'(17);
    tick();
    bus.srv_req = '0;
    checks++; if (bus.err_len !== 1'b1) begin errors++; $display("[TB] FAIL bad_err got %b want 1", bus.err_len); end
    checks++; if (bus.srv_gnt !== '0) begin errors++; $display("[TB] FAIL bad_gnt got %b want 0", bus.srv_gnt); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL bad_busy got %b want 0", bus.busy); end
    tick();
    checks++; if (bus.err_len !== 1'b0) begin errors++; $display("[TB] FAIL bad_pulse got %b want 0", bus.err_len); end
    bus.srv_req = 6'b010010;
    bus.srv_req_len[4] = BW'(2);
    tick();
    bus.srv_req = '0;
    checks++; if (bus.err_len !== 1'b1) begin errors++; $display("[TB] FAIL bad_mix_err got %b want 1", bus.err_len); end
    checks++; if (bus.srv_gnt !== 6'b010000) begin errors++; $display("[TB] FAIL bad_mix_gnt got %b want 010000", bus.srv_gnt); end
    for (int t = 0; t < 6; t++) tick();
  endtask

  task automatic test_arb_en_drop();
    int beats;
    int others;
    doReset();
    bus.arb_en = 1'b1;
    bus.srv_req = 6'b010000;
    bus.srv_req_len[4] = BW'(8);
    beats = 0;
    others = 0;
    for (int t = 1; t <= 30; t++) begin
      tick();
      if (t == 1) begin
        bus.srv_req = 6'b010011;
        bus.srv_req_len[0] = BW'(3);
        bus.srv_req_len[1] = BW'(3);
      end
      if (t == 2) bus.arb_en = 1'b0;
      if (bus.srv_gnt == 6'b010000) beats++;
      else if (bus.srv_gnt != '0) others++;
    end
    checks++; if (beats != 8) begin errors++; $display("[TB] FAIL en_beats got %0d want 8", beats); end
    checks++; if (others != 0) begin errors++; $display("[TB] FAIL en_extra got %0d want 0", others); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL en_idle got %b want 0", bus.busy); end
    bus.srv_req = '0;
  endtask

  task automatic test_reset_mid_burst();
    doReset();
    bus.arb_en = 1'b1;
    bus.srv_req = 6'b000100;
    bus.srv_req_len[2] = BW'(8);
    tick();
    bus.srv_req = 6'b100000;
    bus.srv_req_len[5] = BW'(2);
    tick();
    tick();
    checks++; if (bus.srv_gnt !== 6'b000100) begin errors++; $display("[TB] FAIL mid_beat3 got %b want 000100", bus.srv_gnt); end
    #2 a_rst = 1'b1;
    modelReset();
    #1;
    checks++; if (bus.srv_gnt !== '0) begin errors++; $display("[TB] FAIL mid_async_gnt got %b want 0", bus.srv_gnt); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL mid_async_busy got %b want 0", bus.busy); end
    #3 a_rst = 1'b0;
    #1;
    checks++; if (bus.srv_gnt !== '0) begin errors++; $display("[TB] FAIL mid_noedge got %b want 0", bus.srv_gnt); end
    tick();
    bus.srv_req = '0;
    checks++; if (bus.srv_gnt !== 6'b100000) begin errors++; $display("[TB] FAIL mid_regrant got %b want 100000", bus.srv_gnt); end
    checks++; if (bus.owner_id !== IW'(5)) begin errors++; $display("[TB] FAIL mid_owner got %0d want 5", bus.owner_id); end
    for (int t = 0; t < 6; t++) tick();
  endtask

  task automatic test_random();
    doReset();
    for (int t = 0; t < 400; t++) begin
      if ($urandom_range(0, 1) == 0) begin
        bus.arb_en = ($urandom_range(0, 9) != 0);
        for (int k = 0; k < N; k++) begin
          bus.srv_req[k] = ($urandom_range(0, 2) == 0);
          bus.srv_req_len[k] = BW'($urandom_range(0, 19));
        end
      end
      tick();
      checks++; if (bus.srv_gnt !== expGnt()) begin errors++; $display("[TB] FAIL rnd_gnt t%0d got %b want %b", t, bus.srv_gnt, expGnt()); end
      checks++; if (bus.gnt_last !== (inGrant() && mPos == mLen - 1)) begin
        errors++; $display("[TB] FAIL rnd_last t%0d got %b want %b", t, bus.gnt_last, inGrant() && mPos == mLen - 1);
      end
      checks++; if (bus.owner_id !== expOwner()) begin errors++; $display("[TB] FAIL rnd_owner t%0d got %0d want %0d", t, bus.owner_id, expOwner()); end
      checks++; if (bus.busy !== (mPos >= 0)) begin errors++; $display("[TB] FAIL rnd_busy t%0d got %b want %b", t, bus.busy, mPos >= 0); end
      checks++; if (bus.err_len !== mErr) begin errors++; $display("[TB] FAIL rnd_err t%0d got %b want %b", t, bus.err_len, mErr); end
    end
  endtask

  initial begin
    a_rst = 1'b1;
    bus.arb_en = 1'b0;
    bus.srv_req = '0;
    bus.srv_req_len = '0;
    test_reset();
    test_single();
    test_fairness();
    test_bad_len();
    test_arb_en_drop();
    test_reset_mid_burst();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
